// File: rtl/nn_batch_sequencer_if.sv
// Signal bundle between the batch sequencer, the two-layer NN datapath and the test-input ROM.
// The sequencer side is the master modport; the datapath/ROM/top-level side is the slave.
interface nn_batch_sequencer_if #(
   parameter int CNT_W   = 10,
   parameter int CLASS_W = 8
);
   logic               start;
   logic               dp_ready;
   logic [CLASS_W-1:0] dp_out;
   logic [CLASS_W-1:0] label;
   logic [CNT_W-1:0]   cnt;
   logic               dp_go;
   logic               hidden;
   logic               ld1;
   logic               ld2;
   logic               busy;
   logic [CNT_W-1:0]   correct_cnt;
   logic               batch_done;
   logic               done;
   logic               timeout_err;

   modport master (
      input  start, dp_ready, dp_out, label,
      output cnt, dp_go, hidden, ld1, ld2, busy, correct_cnt, batch_done, done, timeout_err
   );

   modport slave (
      output start, dp_ready, dp_out, label,
      input  cnt, dp_go, hidden, ld1, ld2, busy, correct_cnt, batch_done, done, timeout_err
   );
endinterface

// File: rtl/nn_batch_sequencer.sv
// Steps the test set through the two-layer datapath, scores each result against its label and
// flags batch/run completion, with a down-counting watchdog on each datapath wait.
//
//   state   | meaning
//   --------+------------------------------------------------------------
//   S_IDLE  | waiting for start, all strobes low
//   S_LD1   | load layer-1 registers and launch hidden layer (one cycle)
//   S_HWAIT | waiting for hidden-layer dp_ready
//   S_LD2   | load layer-2 registers and launch output layer (one cycle)
//   S_OWAIT | waiting for output-layer dp_ready
//   S_CHECK | score dp_out against label, advance or finish (one cycle)
//   S_DONE  | run finished, counts held, waiting for restart
module nn_batch_sequencer #(
   parameter int N_SAMPLES = 750,
   parameter int BATCH     = 50,
   parameter int CNT_W     = 10,
   parameter int CLASS_W   = 8,
   parameter int TIMEOUT   = 1023
) (
   input logic                  clk,
   input logic                  rst,
   nn_batch_sequencer_if.master seq
);
   localparam int BAT_W = (BATCH > 1) ? $clog2(BATCH) : 1;
   localparam int WD_W  = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;

   typedef enum logic [2:0] {
      S_IDLE, S_LD1, S_HWAIT, S_LD2, S_OWAIT, S_CHECK, S_DONE
   } state_t;

   state_t             state, state_nxt;
   logic [CNT_W-1:0]   cnt_q, correct_q;
   logic [BAT_W-1:0]   batch_q;
   logic [WD_W-1:0]    wd_q;
   logic               bd_q, terr_q;
   logic [CLASS_W-1:0] dp_class, lbl_class;
   logic               class_match, last_smp, batch_full;
   logic               clear, advance, score, step_batch, batch_end;
   logic               wd_load, wd_dec, wd_expire;

   assign dp_class    = seq.dp_out;
   assign lbl_class   = seq.label;
   assign class_match = (dp_class == lbl_class);
   assign last_smp    = (cnt_q == CNT_W'(N_SAMPLES - 1));
   assign batch_full  = (batch_q == BAT_W'(BATCH - 1));

   always_ff @(posedge clk) begin
      if (rst) state <= S_IDLE;
      else     state <= state_nxt;
   end

   always_comb begin
      state_nxt  = state;
      clear      = 1'b0;
      advance    = 1'b0;
      score      = 1'b0;
      step_batch = 1'b0;
      batch_end  = 1'b0;
      wd_load    = 1'b0;
      wd_dec     = 1'b0;
      wd_expire  = 1'b0;
      case (state)
         S_IDLE, S_DONE: begin
            if (seq.start) begin
               state_nxt = S_LD1;
               clear     = 1'b1;
            end
         end
         S_LD1: begin
            state_nxt = S_HWAIT;
            wd_load   = 1'b1;
         end
         S_HWAIT: begin
            if (seq.dp_ready) state_nxt = S_LD2;
            else if (wd_q == '0) begin
               state_nxt = S_DONE;
               wd_expire = 1'b1;
            end else wd_dec = 1'b1;
         end
         S_LD2: begin
            state_nxt = S_OWAIT;
            wd_load   = 1'b1;
         end
         S_OWAIT: begin
            if (seq.dp_ready) state_nxt = S_CHECK;
            else if (wd_q == '0) begin
               state_nxt = S_DONE;
               wd_expire = 1'b1;
            end else wd_dec = 1'b1;
         end
         S_CHECK: begin
            score      = class_match;
            step_batch = 1'b1;
            // a short final batch still gets its own completion pulse
            batch_end  = batch_full || last_smp;
            if (last_smp) state_nxt = S_DONE;
            else begin
               advance   = 1'b1;
               state_nxt = S_LD1;
            end
         end
         default: state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_q     <= '0;
         correct_q <= '0;
         batch_q   <= '0;
         wd_q      <= '0;
         bd_q      <= 1'b0;
         terr_q    <= 1'b0;
      end else begin
         bd_q <= batch_end;
         if (clear) begin
            cnt_q     <= '0;
            correct_q <= '0;
            batch_q   <= '0;
            terr_q    <= 1'b0;
         end else begin
            if (advance) cnt_q <= cnt_q + CNT_W'(1);
            if (score && (correct_q != {CNT_W{1'b1}})) correct_q <= correct_q + CNT_W'(1);
            if (step_batch) batch_q <= batch_full ? '0 : batch_q + BAT_W'(1);
            if (wd_expire) terr_q <= 1'b1;
         end
         // the wait budget restarts on entry to every wait state
         if (wd_load)     wd_q <= WD_W'(TIMEOUT - 1);
         else if (wd_dec) wd_q <= wd_q - WD_W'(1);
      end
   end

   assign seq.cnt         = cnt_q;
   assign seq.correct_cnt = correct_q;
   assign seq.batch_done  = bd_q;
   assign seq.timeout_err = terr_q;
   assign seq.ld1         = (state == S_LD1);
   assign seq.ld2         = (state == S_LD2);
   assign seq.dp_go       = (state == S_LD1) || (state == S_LD2);
   assign seq.hidden      = (state == S_LD1) || (state == S_HWAIT);
   assign seq.busy        = (state != S_IDLE) && (state != S_DONE);
   assign seq.done        = (state == S_DONE);
endmodule

// File: tb/tb_nn_batch_sequencer.sv
// Bench for nn_batch_sequencer: a per-run timestamp schedule (when each sample's ld1, ld2 and
// CHECK must happen, given the datapath latencies) predicts every output on every cycle.
module tb_nn_batch_sequencer;
   localparam int N  = 750;
   localparam int B  = 50;
   localparam int TO = 1023;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   nn_batch_sequencer_if #(.CNT_W(10), .CLASS_W(8)) bus ();
   nn_batch_sequencer_if #(.CNT_W(10), .CLASS_W(8)) bus2 ();

   nn_batch_sequencer #(.N_SAMPLES(N), .BATCH(B), .CNT_W(10), .CLASS_W(8), .TIMEOUT(TO)) dut (
      .clk(clk), .rst(rst), .seq(bus)
   );
   nn_batch_sequencer #(.N_SAMPLES(7), .BATCH(3), .CNT_W(10), .CLASS_W(8), .TIMEOUT(TO)) dut2 (
      .clk(clk), .rst(rst), .seq(bus2)
   );

   function automatic logic [7:0] rom(input int a);
      return 8'((a * 37 + 5) % 251);
   endfunction

   assign bus.label  = rom(int'(bus.cnt));
   assign bus2.label = rom(int'(bus2.cnt));
   assign bus2.dp_out = bus2.label;

   int k = 0;
   always @(posedge clk) k <= k + 1;

   int n_checks = 0;
   int n_err    = 0;

   task automatic chk(input string nm, input int act, input int exp);
      n_checks++;
      if (act != exp) begin
         n_err++;
         $display("FAIL %s: got %0d, want %0d (cycle %0d)", nm, act, exp, k);
      end
   endtask

   // run schedule: sample i launches at L[i], loads layer 2 at G2[i], is scored at C[i]
   int L[N], G2[N], C[N], dh[N], dq[N], pref[N+1];
   bit match_s[N];
   int last_i, w_idx, D, chk_end, cp, dptr;
   bit chk_on, spur, spam;
   int n_ld1, n_ld2, n_bd, t_done, t_first_ld1, t_last_ld1;
   int e_ld1, e_ld2, e_hid, e_busy, e_done, e_bd, e_terr, e_cnt, e_corr;

   function automatic int adv(input int kk, input int p);
      int q = p;
      while (q < last_i && kk >= L[q+1]) q++;
      return q;
   endfunction

   task automatic plan(input int l0);
      L[0]    = l0;
      pref[0] = 0;
      for (int i = 0; i < N; i++) pref[i+1] = pref[i] + (match_s[i] ? 1 : 0);
      last_i = (w_idx >= 0) ? w_idx : N - 1;
      for (int i = 0; i <= last_i; i++) begin
         if (i == w_idx) begin
            G2[i] = -1;
            C[i]  = -1;
            D     = L[i] + TO + 1;
         end else begin
            G2[i] = L[i] + dh[i] + 2;
            C[i]  = G2[i] + dq[i] + 2;
            if (i < last_i) L[i+1] = C[i] + 1;
            else            D      = C[i] + 1;
         end
      end
   endtask

   always @(negedge clk) begin
      if (chk_on && k >= L[0] && k <= chk_end) begin
         if (k == L[0]) cp = 0;
         cp = adv(k, cp);
         if (k >= D) begin
            e_ld1 = 0; e_ld2 = 0; e_hid = 0; e_busy = 0; e_done = 1;
            e_bd   = (k == D && w_idx < 0) ? 1 : 0;
            e_terr = (w_idx >= 0) ? 1 : 0;
            e_cnt  = last_i;
            e_corr = (w_idx >= 0) ? pref[w_idx] : pref[N];
         end else begin
            e_ld1  = (k == L[cp]) ? 1 : 0;
            e_ld2  = (k == G2[cp]) ? 1 : 0;
            e_hid  = (G2[cp] < 0 || k < G2[cp]) ? 1 : 0;
            e_busy = 1; e_done = 0; e_terr = 0;
            e_bd   = (cp > 0 && k == L[cp] && (cp % B) == 0) ? 1 : 0;
            e_cnt  = cp;
            e_corr = pref[cp];
         end
         chk("ld1", int'(bus.ld1), e_ld1);
         chk("ld2", int'(bus.ld2), e_ld2);
         chk("dp_go", int'(bus.dp_go), e_ld1 | e_ld2);
         chk("hidden", int'(bus.hidden), e_hid);
         chk("busy", int'(bus.busy), e_busy);
         chk("done", int'(bus.done), e_done);
         chk("batch_done", int'(bus.batch_done), e_bd);
         chk("timeout_err", int'(bus.timeout_err), e_terr);
         chk("cnt", int'(bus.cnt), e_cnt);
         chk("correct_cnt", int'(bus.correct_cnt), e_corr);
         if (bus.ld1) begin
            n_ld1++;
            t_last_ld1 = k;
            if (t_first_ld1 < 0) t_first_ld1 = k;
         end
         if (bus.ld2) n_ld2++;
         if (bus.batch_done) n_bd++;
         if (bus.done && t_done < 0) t_done = k;
      end
   end

   task automatic drive();
      int i;
      bit r;
      if (k < L[0] || k >= D) begin
         bus.dp_ready = 1'b0;
         bus.dp_out   = 8'd0;
      end else begin
         dptr = adv(k, dptr);
         i    = dptr;
         r    = (i != w_idx) && (k == L[i] + dh[i] + 1);
         if (G2[i] >= 0 && k == G2[i] + dq[i] + 1) r = 1'b1;
         if (spur && (k == L[i] || k == G2[i] || k == C[i])) r = 1'b1;
         bus.dp_ready = r;
         bus.dp_out   = match_s[i] ? rom(i) : rom(i) + 8'd1;
      end
      bus.start = spam && (k >= L[0]) && (k + 5 < D) && ((k % 211) == 7);
   endtask

   task automatic check_zero(input string nm);
      chk({nm, " cnt"}, int'(bus.cnt), 0);
      chk({nm, " correct_cnt"}, int'(bus.correct_cnt), 0);
      chk({nm, " flags"}, int'({bus.ld1, bus.ld2, bus.dp_go, bus.hidden, bus.busy,
                              bus.batch_done, bus.done, bus.timeout_err}), 0);
   endtask

   task automatic do_run(input bit mism, input bit varlat, input int wd, input int rst_samp,
                         input bit sp, input bit sm);
      int kr;
      for (int i = 0; i < N; i++) begin
         dh[i]      = varlat ? int'($urandom_range(20, 0)) : 0;
         dq[i]      = varlat ? int'($urandom_range(20, 0)) : 0;
         match_s[i] = !(mism && (i % 3) == 0);
      end
      w_idx = wd; spur = sp; spam = sm;
      n_ld1 = 0; n_ld2 = 0; n_bd = 0; t_done = -1; t_first_ld1 = -1; t_last_ld1 = -1;
      @(posedge clk); #1;
      plan(k + 1);
      kr      = (rst_samp >= 0) ? L[rst_samp] + 2 : -1;
      chk_end = (kr >= 0) ? kr : D + 2;
      dptr    = 0;
      chk_on  = 1'b1;
      bus.start = 1'b1;
      while (k < chk_end) begin
         @(posedge clk); #1;
         drive();
      end
      if (kr >= 0) begin
         rst          = 1'b1;
         bus.start    = 1'b0;
         bus.dp_ready = 1'b0;
         @(posedge clk); #1;
         chk_on = 1'b0;
         check_zero("mid-run reset");
         rst = 1'b0;
      end else begin
         @(posedge clk); #1;
         chk_on = 1'b0;
      end
      bus.start    = 1'b0;
      bus.dp_ready = 1'b0;
   endtask

   int bd2[$];
   int t_done2, l2;
   bit go_last;

   initial begin
      bus.start = 1'b0; bus.dp_ready = 1'b0; bus.dp_out = 8'd0;
      bus2.start = 1'b0; bus2.dp_ready = 1'b0;
      chk_on = 1'b0; chk_end = -1; L[0] = 0; D = 0; cp = 0; dptr = 0;
      rst = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      check_zero("reset");
      chk("reset dut2 busy/done", int'({bus2.busy, bus2.done, bus2.batch_done}), 0);
      rst = 1'b0;

      // partial final batch: 7 samples in batches of 3, datapath answers one cycle after dp_go
      go_last = 1'b0; t_done2 = -1;
      @(posedge clk); #1;
      bus2.start = 1'b1;
      l2 = k + 1;
      for (int c = 0; c < 45; c++) begin
         @(posedge clk); #1;
         bus2.start    = 1'b0;
         bus2.dp_ready = go_last;
         go_last       = bus2.dp_go;
         @(negedge clk);
         if (bus2.batch_done) bd2.push_back(k - l2);
         if (bus2.done && t_done2 < 0) t_done2 = k - l2;
      end
      bus2.dp_ready = 1'b0;
      chk("partial batch pulse count", bd2.size(), 3);
      chk("partial batch pulse 0", (bd2.size() > 0) ? bd2[0] : -1, 15);
      chk("partial batch pulse 1", (bd2.size() > 1) ? bd2[1] : -1, 30);
      chk("partial batch pulse 2", (bd2.size() > 2) ? bd2[2] : -1, 35);
      chk("partial done rise", t_done2, 35);
      chk("partial correct_cnt", int'(bus2.correct_cnt), 7);
      chk("partial final cnt", int'(bus2.cnt), 6);

      do_run(1'b0, 1'b0, -1, -1, 1'b0, 1'b0);
      chk("ideal run length", t_done - t_first_ld1, 3750);
      chk("ideal correct_cnt", int'(bus.correct_cnt), 750);
      chk("ideal batch pulses", n_bd, 15);
      chk("ideal final cnt", int'(bus.cnt), 749);

      do_run(1'b1, 1'b0, -1, -1, 1'b0, 1'b0);
      chk("mismatch correct_cnt", int'(bus.correct_cnt), 500);
      chk("mismatch batch pulses", n_bd, 15);

      do_run(1'b0, 1'b1, -1, -1, 1'b1, 1'b0);
      chk("varlat correct_cnt", int'(bus.correct_cnt), 750);
      chk("varlat batch pulses", n_bd, 15);
      chk("varlat final cnt", int'(bus.cnt), 749);
      chk("varlat ld1 count", n_ld1, 750);
      chk("varlat ld2 count", n_ld2, 750);

      do_run(1'b0, 1'b0, 7, -1, 1'b0, 1'b0);
      chk("watchdog timeout_err", int'(bus.timeout_err), 1);
      chk("watchdog done", int'(bus.done), 1);
      chk("watchdog cnt", int'(bus.cnt), 7);
      chk("watchdog correct_cnt", int'(bus.correct_cnt), 7);
      chk("watchdog wait length", t_done - t_last_ld1, 1024);
      chk("watchdog batch pulses", n_bd, 0);

      do_run(1'b0, 1'b0, -1, 300, 1'b0, 1'b0);
      repeat (2) @(posedge clk);
      #1;
      check_zero("idle after reset");

      do_run(1'b0, 1'b0, -1, -1, 1'b0, 1'b1);
      chk("restart correct_cnt", int'(bus.correct_cnt), 750);
      chk("restart batch pulses", n_bd, 15);
      chk("restart final cnt", int'(bus.cnt), 749);
      chk("restart ld1 count", n_ld1, 750);
      chk("restart done", int'(bus.done), 1);

      $display("Result: errors=%0d of %0d checks", n_err, n_checks);
      $finish;
   end
endmodule

// File: doc/nn_batch_sequencer.md
# nn_batch_sequencer

Sequencer that runs the two-layer neural-network datapath over a stored test set: it steps the test-sample index, issues the layer-1 and layer-2 load and launch strobes, waits on the datapath `ready` handshake, scores each classification against its label, and flags batch and run completion. It sits between the top-level start/done interface and the datapath/test-input ROM, replacing hand-wired strobe control with a single counted schedule plus a per-layer watchdog.

## Interface
- `N_SAMPLES`, 750: samples per run.
- `BATCH`, 50: samples per batch.
- `CNT_W`, 10: width of sample index and score.
- `CLASS_W`, 8: width of datapath class output and label.
- `TIMEOUT`, 1023: maximum cycles spent in one wait state.

Ports:
- `clk`  in  1  single clock, rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `start`  in  1  run request; sampled only in IDLE and DONE.
- `dp_ready`  in  1  datapath layer complete.
- `dp_out`  in  CLASS_W  datapath class result.
- `label`  in  CLASS_W  expected class for the current `cnt`, combinational from the ROM.
- `cnt`  out  CNT_W  test-sample index driving the input ROM.
- `dp_go`  out  1  one-cycle layer launch.
- `hidden`  out  1  1 = hidden-layer phase, 0 = output-layer phase.
- `ld1`  out  1  one-cycle load of layer-1 registers.
- `ld2`  out  1  one-cycle load of layer-2 registers.
- `busy`  out  1  high in every state except IDLE and DONE.
- `correct_cnt`  out  CNT_W  number of matching classifications this run.
- `batch_done`  out  1  one-cycle pulse per completed batch.
- `done`  out  1  level; high from run end until restart.
- `timeout_err`  out  1  sticky watchdog flag.

## Operation
States:
- **IDLE**: all strobes low.
  - `start` → LD1; clears `cnt`, `correct_cnt`, `timeout_err` and the batch counter.
- **LD1**: `ld1=1`, `dp_go=1`, `hidden=1` for one cycle → HWAIT.
- **HWAIT**: `hidden=1`.
  - `dp_ready` → LD2.
- **LD2**: `ld2=1`, `dp_go=1`, `hidden=0` for one cycle → OWAIT.
- **OWAIT**: `hidden=0`.
  - `dp_ready` → CHECK.
- **CHECK**: one cycle.
  - If `dp_out == label`, `correct_cnt` += 1.
  - If `cnt == N_SAMPLES-1` → DONE.
  - Otherwise `cnt` += 1 and → LD1.

Counters and flags:
- Batch counter counts 0..BATCH-1 and wraps.
  - `batch_done` pulses after the CHECK that completes a batch.
  - It also pulses after the final sample when `N_SAMPLES` is not a multiple of `BATCH`.
- **DONE**: `done=1`, `cnt` and `correct_cnt` held.
  - `start` → LD1 with the same clears as in IDLE.
- Watchdog: counts cycles in HWAIT/OWAIT and clears on entry to each wait state.
  - At TIMEOUT it sets `timeout_err`, skips scoring and → DONE.
- `dp_ready` is ignored outside HWAIT/OWAIT. `start` is ignored while `busy`.
- `correct_cnt` saturates at 2^CNT_W-1. It cannot exceed `N_SAMPLES` in normal use.
- `label` is compared in CHECK against the unchanged `cnt`, so the ROM address is stable.

## Timing
- Reset values:
  - State is IDLE.
  - `cnt`, `correct_cnt`, `dp_go`, `hidden`, `ld1`, `ld2`, `busy`, `batch_done`, `done` and `timeout_err` are all 0.
- All outputs are registered or decoded from state only; there is no combinational path from inputs to outputs.
- Reset asserted mid-run returns to IDLE on the next edge and discards all counts.
- `start` in IDLE → `ld1` and `dp_go` high the next cycle.
- With `dp_ready` returned one cycle after each `dp_go`, each sample takes 5 cycles (LD1, HWAIT, LD2, OWAIT, CHECK).
  - A full run of 750 samples takes 3750 cycles from the first LD1 to DONE.
- `dp_ready` high on the first HWAIT cycle is accepted, giving a 1-cycle wait.
- `batch_done` is high in the cycle after the relevant CHECK.
- On the final sample, `batch_done` and `done` rise on the same edge.

## Test plan
- **Full run with an ideal datapath**: `dp_ready` returns 1 cycle after `dp_go`, `dp_out == label` always.
  - `done` rises 3750 cycles after the first LD1.
  - `correct_cnt` = 750, 15 `batch_done` pulses, `cnt` = 749.
- **Mismatch scoring**: `dp_out` is wrong for samples whose `cnt` is a multiple of 3.
  - Final `correct_cnt` = 500.
- **Variable latency**: `dp_ready` delayed 0–20 random cycles; spurious `dp_ready` pulses driven in LD1/LD2/CHECK.
  - Strobe order per sample is exactly ld1, ld2, one CHECK.
  - Results match the ideal run.
- **Watchdog**: `dp_ready` never returns on sample 7.
  - `timeout_err` = 1 and `done` = 1 after 1023 wait cycles.
  - `cnt` = 7, `correct_cnt` = 7.
- **Reset and restart**: `rst` pulsed at sample 300.
  - IDLE next cycle with all outputs 0.
  - A new `start` completes a clean 750-sample run.
  - `start` pulses mid-run have no effect.
- **Partial final batch**: `N_SAMPLES`=7, `BATCH`=3.
  - `batch_done` pulses after samples 2, 5 and 6.
  - The last pulse coincides with `done` rising.
